// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver, pclk domain, with an optional parity bit
//               enabled by the UART_RX_PARITY_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 6771,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       rx_serial,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);
    localparam int                 c_CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3,
        S_BREAK  = 3'd4
`ifdef UART_RX_PARITY_EN
        , S_PARITY = 3'd5
`endif
    } state_t;

    logic               r_sync1, r_rxs, r_rxs_d;
    state_t             r_state, w_state_nxt;
    logic [c_CNT_W-1:0] r_clk_cnt, w_clk_cnt_nxt;
    logic [2:0]         r_bit_cnt, w_bit_cnt_nxt;
    logic [7:0]         r_shift, w_shift_nxt;
    logic [7:0]         r_data, w_data_nxt;
    logic               r_valid, w_valid_nxt;
    logic               r_ferr, w_ferr_nxt;
    logic               w_fall;
`ifdef UART_RX_PARITY_EN
    logic               r_perr, w_perr_nxt;
    logic               r_par_bad, w_par_bad_nxt;
`endif

    // Two-flop synchroniser; the third flop only serves edge detection.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_rxs   <= 1'b1;
            r_rxs_d <= 1'b1;
        end else begin
            r_sync1 <= rx_serial;
            r_rxs   <= r_sync1;
            r_rxs_d <= r_rxs;
        end
    end

    assign w_fall = r_rxs_d & ~r_rxs;

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr    <= 1'b0;
            r_par_bad <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_clk_cnt <= w_clk_cnt_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_data    <= w_data_nxt;
            r_valid   <= w_valid_nxt;
            r_ferr    <= w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
            r_perr    <= w_perr_nxt;
            r_par_bad <= w_par_bad_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clk_cnt_nxt = r_clk_cnt;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_data_nxt    = r_data;
        w_valid_nxt   = 1'b0;
        w_ferr_nxt    = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_perr_nxt    = 1'b0;
        w_par_bad_nxt = r_par_bad;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_state_nxt   = S_START;
                    w_clk_cnt_nxt = '0;
                end
            end
            S_START: begin
                // Mid-start-bit check rejects glitches shorter than half a bit.
                if (r_clk_cnt == c_HALF_LAST) begin
                    w_clk_cnt_nxt = '0;
                    w_bit_cnt_nxt = '0;
                    w_state_nxt   = r_rxs ? S_IDLE : S_DATA;
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (r_clk_cnt == c_BIT_LAST) begin
                    w_clk_cnt_nxt = '0;
                    w_shift_nxt   = {r_rxs, r_shift[7:1]};
                    if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    end
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (r_clk_cnt == c_BIT_LAST) begin
                    w_clk_cnt_nxt = '0;
                    w_par_bad_nxt = r_rxs ^ (^r_shift) ^ PARITY_ODD;
                    w_state_nxt   = S_STOP;
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (r_clk_cnt == c_BIT_LAST) begin
                    w_clk_cnt_nxt = '0;
                    if (r_rxs) begin
                        w_state_nxt = S_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (r_par_bad) begin
                            w_perr_nxt = 1'b1;
                        end else begin
                            w_valid_nxt = 1'b1;
                            w_data_nxt  = r_shift;
                        end
`else
                        w_valid_nxt = 1'b1;
                        w_data_nxt  = r_shift;
`endif
                    end else begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = S_BREAK;
                    end
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + 1'b1;
                end
            end
            S_BREAK: begin
                if (r_rxs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign frame_err = r_ferr;
    assign busy      = (r_state != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_perr;
`else
    // No parity bit in this build; PARITY_ODD has no effect here.
    assign parity_err = 1'b0 & PARITY_ODD;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Randomised self-checking bench for uart_rx with a frame-level
//               reference model (expected strobe kind, data and arrival cycle).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;
    localparam int CPB  = 16;
    localparam bit PODD = 1'b0;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
    localparam int LAT_LIT    = 171;
    localparam int FRAME_LIT  = 176;
`else
    localparam int FRAME_BITS = 10;
    localparam int LAT_LIT    = 155;
    localparam int FRAME_LIT  = 160;
`endif
    // Strobe one cycle after the mid-stop-bit sample, plus the sync delay.
    localparam int LAT = (FRAME_BITS - 1) * CPB + CPB / 2 + 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_serial = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, parity_err, busy;

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(PODD)) dut (
        .pclk       (clk),
        .rst        (rst),
        .rx_serial  (rx_serial),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    typedef struct {
        logic [2:0]  kind;   // {valid, frame_err, parity_err}
        logic [7:0]  data;
        int unsigned at;
    } ev_t;

    int unsigned cyc = 0;
    ev_t         exp_q[$];
    logic [7:0]  model_data = 8'h00;
    int unsigned vcyc[$];
    logic [7:0]  vdat[$];
    int          n_chk = 0, n_fail = 0;
    int          n_strobes = 0, n_ferr = 0, n_perr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_range(input string name, input int unsigned act, input int unsigned lo,
                               input int unsigned hi);
        n_chk++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
        end
    endtask

    // Compare process: every strobe must match the next expected frame outcome.
    always @(negedge clk) begin : cmp
        int  cnt;
        ev_t e;
        if (!rst) begin
            cnt = int'(rx_valid) + int'(frame_err) + int'(parity_err);
            check("strobe_exclusive", 32'(cnt > 1), 32'd0);
            if (cnt != 0) begin
                n_strobes++;
                if (rx_valid) begin vcyc.push_back(cyc); vdat.push_back(rx_data); end
                if (frame_err) n_ferr++;
                if (parity_err) n_perr++;
                if (exp_q.size() == 0) begin
                    check("spurious_strobe", 32'({rx_valid, frame_err, parity_err}), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_kind", 32'({rx_valid, frame_err, parity_err}), 32'(e.kind));
                    check_range("strobe_cycle", cyc, e.at - 1, e.at + 1);
                    check("busy_at_strobe", 32'(busy), 32'(e.kind == 3'b010));
                    if (e.kind == 3'b100) model_data = e.data;
                end
            end
            if (exp_q.size() != 0 && cyc > exp_q[0].at + 1) begin
                check("missing_strobe", 32'd0, 32'(exp_q[0].kind));
                void'(exp_q.pop_front());
            end
            check("rx_data", 32'(rx_data), 32'(model_data));
`ifndef UART_RX_PARITY_EN
            check("parity_err_tied", 32'(parity_err), 32'd0);
`endif
        end
    end

    task automatic drive_bit(input logic b);
        rx_serial = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip,
                              input bit record, output int unsigned s);
        ev_t e;
        s = cyc;
        if (record) begin
            e.kind = !stop_b ? 3'b010 : (par_flip ? 3'b001 : 3'b100);
            e.data = d;
            e.at   = s + LAT;
            exp_q.push_back(e);
        end
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ PODD ^ par_flip);
`endif
        drive_bit(stop_b);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        exp_q.delete();
        model_data = 8'h00;
        repeat (n) @(negedge clk);
        check("reset_outputs", 32'({rx_data, rx_valid, frame_err, parity_err, busy}), 32'd0);
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #(600_000);
        $display("FAIL watchdog: got timeout at cycle %0d, required completion", cyc);
        $fatal(1, "timeout");
    end

    initial begin : main
        int unsigned s, s2;
        int          base, r;
        logic [7:0]  d;
        logic        pf;
        @(negedge clk);
        do_reset(4);
        repeat (5) @(negedge clk);

        // Single frame A5
        base = vcyc.size();
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1, s);
        repeat (2 * CPB) @(negedge clk);
        check("a5_count", 32'(vcyc.size() - base), 32'd1);
        if (vcyc.size() > base) begin
            check("a5_data", 32'(vdat[vcyc.size()-1]), 32'hA5);
            check_range("a5_latency", vcyc[vcyc.size()-1] - s, LAT_LIT - 1, LAT_LIT + 1);
        end
        check("a5_busy_idle", 32'(busy), 32'd0);
        check("a5_no_errors", 32'(n_ferr + n_perr), 32'd0);

        // Back-to-back 00, FF
        base = vcyc.size();
        send_frame(8'h00, 1'b1, 1'b0, 1'b1, s);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b1, s2);
        repeat (2 * CPB) @(negedge clk);
        check("b2b_count", 32'(vcyc.size() - base), 32'd2);
        if (vcyc.size() >= base + 2) begin
            check("b2b_data0", 32'(vdat[base]), 32'h00);
            check("b2b_data1", 32'(vdat[base+1]), 32'hFF);
            check_range("b2b_spacing", vcyc[base+1] - vcyc[base], FRAME_LIT - 1, FRAME_LIT + 1);
        end

        // Bad stop bit then a long break
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, s);
        repeat (40) @(negedge clk);
        check("break_ferr_count", 32'(n_ferr), 32'd1);
        check("break_rx_data_kept", 32'(rx_data), 32'hFF);
        check("break_busy_high", 32'(busy), 32'd1);
        rx_serial = 1'b1;
        repeat (5) @(negedge clk);
        check("break_busy_released", 32'(busy), 32'd0);

        // Short glitch then a good frame
        base = n_strobes;
        rx_serial = 1'b0;
        repeat (5) @(negedge clk);
        rx_serial = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("glitch_no_strobe", 32'(n_strobes - base), 32'd0);
        check("glitch_idle", 32'(busy), 32'd0);
        send_frame(8'h81, 1'b1, 1'b0, 1'b1, s);
        repeat (2 * CPB) @(negedge clk);
        check("after_glitch_data", 32'(rx_data), 32'h81);

        // Reset in the middle of data bit 4 of 55; transmitter abandons the frame
        base = n_strobes;
        d = 8'h55;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        rx_serial = d[4];
        repeat (CPB / 2) @(negedge clk);
        do_reset(1);
        rx_serial = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("rst_no_strobe", 32'(n_strobes - base), 32'd0);
        check("rst_rx_data_cleared", 32'(rx_data), 32'h00);
        send_frame(8'h12, 1'b1, 1'b0, 1'b1, s);
        repeat (2 * CPB) @(negedge clk);
        check("after_rst_data", 32'(rx_data), 32'h12);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0, 1'b1, s);
        repeat (2 * CPB) @(negedge clk);
        check("par_good_data", 32'(rx_data), 32'h07);
        base = n_perr;
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, s);
        repeat (2 * CPB) @(negedge clk);
        check("par_bad_strobe", 32'(n_perr - base), 32'd1);
        check("par_bad_data_kept", 32'(rx_data), 32'h07);
`endif

        // Randomised traffic: good frames, bad stop bits, glitches
        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 99));
            d = 8'($urandom);
            if (r < 15) begin
                send_frame(d, 1'b0, 1'b0, 1'b1, s);
                repeat ($urandom_range(0, 30)) @(negedge clk);
                rx_serial = 1'b1;
                repeat ($urandom_range(2, 10)) @(negedge clk);
            end else if (r < 30) begin
                rx_serial = 1'b0;
                repeat ($urandom_range(1, CPB / 2 - 1)) @(negedge clk);
                rx_serial = 1'b1;
                repeat (CPB) @(negedge clk);
            end else begin
                pf = 1'b0;
`ifdef UART_RX_PARITY_EN
                pf = (r < 42);
`endif
                send_frame(d, 1'b1, pf, 1'b1, s);
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        rx_serial = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
